mul_div_ctrl: RTL and testbench

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

---
 rtl/mul_div_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mul_div_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl.sv
// RV32M multiply/divide controller: a combinational multiplier sampled after
// MUL_LAT cycles and a 32-step radix-2 restoring divider, with flush and async reset.

module mult #(
    parameter int W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           x,      // treat a as signed
    input  logic           y,      // treat b as signed
    output logic [2*W-1:0] p
);
    logic signed [W:0]     a_ext;
    logic signed [W:0]     b_ext;
    logic signed [2*W+1:0] full;

    always_comb begin
        a_ext = {x & a[W-1], a};
        b_ext = {y & b[W-1], b};
        full  = a_ext * b_ext;
        p     = full[2*W-1:0];
    end
endmodule

module mul_div_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic        o_busy,
    output logic [1:0]  o_dbg_state
);
    // Handshake: a request is taken on a rising edge where i_valid && o_ready;
    // the result is presented for exactly one cycle with o_valid, never back-pressured.
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_n;

    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        x_q, y_q;
    logic [31:0] divisor_q, quo_q, rem_q;
    logic        neg_quo_q, neg_rem_q;
    logic [5:0]  cnt_q;
    logic [31:0] result_q;

    logic        accept;
    logic        div_signed, div_zero, div_ovf;
    logic        mul_done, div_last;
    logic [63:0] product;
    logic [31:0] mul_word;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] rem_n, quo_n, quo_fix, rem_fix, div_word;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? -v : v;
    endfunction

    assign accept     = i_valid && o_ready;
    assign div_signed = !i_op[0];
    assign div_zero   = (i_rs2 == 32'h0);
    assign div_ovf    = div_signed && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign mul_done   = (state == MUL) && (cnt_q == 6'(MUL_LAT));
    assign div_last   = (state == DIV) && (cnt_q == 6'd31);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        o_ready     = (state == IDLE) && !i_flush;
        o_valid     = (state == DONE) && !i_flush;
        o_busy      = (state != IDLE);
        o_dbg_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!i_op[2])                state_n = MUL;
                    else if (div_zero || div_ovf) state_n = DONE;
                    else                          state_n = DIV;
                end
            end
            MUL:     if (mul_done) state_n = DONE;
            DIV:     if (div_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (i_flush) state_n = IDLE;
    end

    mult #(.W(32)) u_mult (
        .a (a_q),
        .b (b_q),
        .x (x_q),
        .y (y_q),
        .p (product)
    );

    assign mul_word = (op_q[1:0] == 2'b00) ? product[31:0] : product[63:32];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        fits     = (shifted >= {1'b0, divisor_q});
        rem_n    = fits ? (shifted[31:0] - divisor_q) : shifted[31:0];
        quo_n    = {quo_q[30:0], fits};
        quo_fix  = neg_quo_q ? -quo_n : quo_n;
        rem_fix  = neg_rem_q ? -rem_n : rem_n;
        div_word = op_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q      <= 3'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            divisor_q <= 32'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= 6'd0;
            result_q  <= 32'd0;
        end else if (accept) begin
            op_q      <= i_op;
            a_q       <= i_rs1;
            b_q       <= i_rs2;
            x_q       <= !i_op[2] && (i_op[1:0] != 2'b11);
            y_q       <= !i_op[2] && !i_op[1];
            cnt_q     <= i_op[2] ? 6'd0 : 6'd1;
            divisor_q <= mag(i_rs2, div_signed);
            quo_q     <= mag(i_rs1, div_signed);
            rem_q     <= 32'd0;
            neg_quo_q <= div_signed && (i_rs1[31] ^ i_rs2[31]);
            neg_rem_q <= div_signed && i_rs1[31];
            // Special divides bypass the iteration and finish next cycle.
            if (i_op[2] && div_zero)
                result_q <= i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
            else if (i_op[2] && div_ovf)
                result_q <= i_op[1] ? 32'h0 : 32'h8000_0000;
        end else if (state == MUL) begin
            cnt_q <= cnt_q + 6'd1;
            if (mul_done && !i_flush) result_q <= mul_word;
        end else if (state == DIV) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q + 6'd1;
            if (div_last && !i_flush) result_q <= div_word;
        end
    end

    assign o_result = result_q;
endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl: directed vectors, flush/reset scenarios
// and randomized back-to-back traffic against an arithmetic reference model.

module tb_mul_div_ctrl;
    localparam int MUL_LAT = 2;

    logic        i_clk, i_rst_n, i_valid, i_flush;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic        o_ready, o_valid, o_busy;
    logic [31:0] o_result;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    int doubles = 0;
    logic prev_valid = 1'b0;
    logic [31:0] last_result = 32'd0;
    logic hold_known = 1'b1;

    mul_div_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .o_result    (o_result),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_valid === 1'b1) strobes++;
        if (o_valid === 1'b1 && prev_valid) doubles++;
        prev_valid = (o_valid === 1'b1);
    end

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: begin
                if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
                if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return op[1] ? 32'd0 : 32'h8000_0000;
                case (op)
                    3'd4:    return ia / ib;
                    3'd5:    return a / b;
                    3'd6:    return ia % ib;
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return MUL_LAT + 1;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one request in the current cycle and follows it to its strobe.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] exp, res;
        int exp_lat, cyc;
        logic seen, busy_ok;
        exp = ref_result(op, a, b);
        exp_lat = ref_latency(op, a, b);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: ready=%b busy=%b valid=%b, required 1/0/0",
                     tag, o_ready, o_busy, o_valid);
        end
        if (hold_known) begin
            checks++;
            if (o_result !== last_result) begin
                errors++;
                $display("FAIL %s hold: result=%h, required %h", tag, o_result, last_result);
            end
        end
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_op = 3'($urandom); i_rs1 = $urandom; i_rs2 = $urandom;
        seen = 1'b0; cyc = 0; busy_ok = 1'b1; res = 32'd0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge i_clk);
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_valid === 1'b1) begin seen = 1'b1; cyc = c; res = o_result; end
            @(posedge i_clk); #1;
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy: dropped before strobe, required high cycles 1..%0d", tag, exp_lat);
        end
        checks++;
        if (!seen || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: strobe seen=%b cycle=%0d, required cycle %0d",
                     tag, seen, cyc, exp_lat);
        end
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s result: op=%0d a=%h b=%h got %h, required %h", tag, op, a, b, res, exp);
        end
        last_result = exp;
        hold_known = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_op = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b ready=%b, required 0/0/1", o_valid, o_busy, o_ready);
        end
        checks++;
        if (o_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result: got %h, required 00000000", o_result);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        last_result = 32'd0;
    endtask

    task automatic test_mul_vectors();
        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7xm3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
    endtask

    task automatic test_div_vectors();
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        do_op(3'd5, 32'hFFFF_FFF9, 32'd2, "divu_big_2");
        do_op(3'd7, 32'hFFFF_FFF9, 32'd2, "remu_big_2");
    endtask

    task automatic test_special();
        do_op(3'd4, 32'd5, 32'd0, "div_by_zero");
        do_op(3'd7, 32'd5, 32'd0, "remu_by_zero");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    endtask

    task automatic test_flush_blocks_accept();
        i_flush = 1'b1; i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'd9; i_rs2 = 32'd2;
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: ready=%b, required 0", o_ready);
        end
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept: busy=%b, required 0", o_busy);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_flush_mid_div();
        int s0;
        i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'hFFFF_FFF9; i_rs2 = 32'd2;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        s0 = strobes;
        repeat (9) begin @(posedge i_clk); #1; end
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_cycle10: valid=%b ready=%b, required 0/0", o_valid, o_ready);
        end
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        do_op(3'd0, 32'd3, 32'hFFFF_FFFB, "mul_after_flush");
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL flush_div_strobes: got %0d strobes, required %0d", strobes - s0, 1);
        end
    endtask

    task automatic test_flush_done();
        int s0;
        i_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'd7; i_rs2 = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (MUL_LAT) begin @(posedge i_clk); #1; end
        s0 = strobes;
        i_flush = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_done_cycle: valid=%b busy=%b, required 0/1", o_valid, o_busy);
        end
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || strobes != s0) begin
            errors++;
            $display("FAIL flush_done_after: busy=%b strobes=%0d, required 0/%0d", o_busy, strobes, s0);
        end
        @(posedge i_clk); #1;
        hold_known = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int s0;
        i_valid = 1'b1; i_op = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        s0 = strobes;
        repeat (19) begin @(posedge i_clk); #1; end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b valid=%b ready=%b result=%h, required 0/0/1/00000000",
                     o_busy, o_valid, o_ready, o_result);
        end
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        last_result = 32'd0;
        hold_known = 1'b1;
        do_op(3'd5, 32'd100, 32'd7, "divu_after_reset");
        checks++;
        if (strobes != s0 + 1) begin
            errors++;
            $display("FAIL reset_strobes: got %0d strobes, required %0d", strobes - s0, 1);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_back_to_back_random();
        for (int n = 0; n < 30; n++) begin
            do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), "random");
        end
    endtask

    initial begin
        test_reset();
        test_mul_vectors();
        test_div_vectors();
        test_special();
        test_flush_blocks_accept();
        test_flush_mid_div();
        test_flush_done();
        test_reset_mid_op();
        test_back_to_back_random();
        checks++;
        if (doubles != 0) begin
            errors++;
            $display("FAIL single_strobe: %0d consecutive o_valid pairs, required 0", doubles);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
